// File: rtl/ifft_data_output_handler.sv
// Buffers one IFFT frame (scaled real parts), then replays it over valid/ready; first sample
// valid 1 cycle after the frame-ending beat; IFFT is held off (tReady=0) until the frame drains.
module ifft_data_output_handler #(
   parameter int FRAME_LEN   = 1024,
   parameter int ADDR_W      = 10,
   parameter int SCALE_SHIFT = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] tData,
   input  logic        tValid,
   input  logic        tLast,
   output logic        tReady,
   output logic [15:0] value,
   output logic        valueValid,
   output logic        valueLast,
   input  logic        valueReady,
   output logic        frameDone,
   output logic        lastErr
);

   typedef enum logic {RECV, SEND} stateT;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

   stateT              state;
   logic [15:0]        frameBuf [FRAME_LEN];
   logic [ADDR_W-1:0]  wptr;
   logic [ADDR_W-1:0]  rptr;
   logic [ADDR_W:0]    frameLen;

   logic signed [15:0] realPart;
   logic signed [15:0] scaled;
   logic               unusedImag;
   logic               beatAcc;
   logic               frameEnd;
   logic               atLastIdx;
   logic               loadOut;
   logic               lastXfer;

   assign realPart   = tData[15:0];
   assign scaled     = realPart >>> SCALE_SHIFT;
   assign unusedImag = ^tData[31:16];

   assign atLastIdx = (wptr == LAST_IDX);
   assign beatAcc   = (state == RECV) && tValid && tReady;
   assign frameEnd  = beatAcc && (tLast || atLastIdx);

   // The output register doubles as the synchronous read port: it only reloads when empty
   // or being consumed, so one sample per cycle flows with valueReady high and holds otherwise.
   assign loadOut  = (state == SEND) && !(valueValid && valueLast) && (!valueValid || valueReady);
   assign lastXfer = (state == SEND) && valueValid && valueLast && valueReady;

   always_ff @(posedge CLK) begin
      if (beatAcc) begin
         frameBuf[wptr] <= scaled;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= RECV;
         wptr       <= '0;
         rptr       <= '0;
         frameLen   <= '0;
         tReady     <= 1'b0;
         value      <= '0;
         valueValid <= 1'b0;
         valueLast  <= 1'b0;
         frameDone  <= 1'b0;
         lastErr    <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         case (state)
            RECV: begin
               if (frameEnd) begin
                  frameLen <= {1'b0, wptr} + LEN_ONE;
                  // early tLast or missing tLast on the final slot
                  lastErr  <= lastErr | (tLast != atLastIdx);
                  tReady   <= 1'b0;
                  rptr     <= '0;
                  state    <= SEND;
               end else begin
                  tReady <= 1'b1;
                  if (beatAcc) begin
                     wptr <= wptr + PTR_ONE;
                  end
               end
            end
            SEND: begin
               if (lastXfer) begin
                  valueValid <= 1'b0;
                  valueLast  <= 1'b0;
                  frameDone  <= 1'b1;
                  tReady     <= 1'b1;
                  wptr       <= '0;
                  state      <= RECV;
               end else if (loadOut) begin
                  value      <= frameBuf[rptr];
                  valueValid <= 1'b1;
                  valueLast  <= ({1'b0, rptr} == (frameLen - LEN_ONE));
                  rptr       <= rptr + PTR_ONE;
               end
            end
            default: state <= RECV;
         endcase
      end
   end

endmodule

// File: tb/tb_ifft_data_output_handler.sv
// Bench for ifft_data_output_handler: two instances (shift 0 and 2) share stimulus and are
// checked against a frame-level reference built from floor-division scaling and sample queues.
module tb_ifft_data_output_handler;

   localparam int FL = 8;
   localparam int AW = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] tData;
   logic        tValid;
   logic        tLast;
   logic        valueReady;

   logic        tReady0, valueValid0, valueLast0, frameDone0, lastErr0;
   logic [15:0] value0;
   logic        tReady2, valueValid2, valueLast2, frameDone2, lastErr2;
   logic [15:0] value2;

   int          nAssert = 0;
   int          nFail   = 0;
   logic [31:0] dataPlan [$];
   logic [15:0] expRaw [$];
   logic        modelErr;

   always #5 CLK = ~CLK;

   ifft_data_output_handler #(.FRAME_LEN(FL), .ADDR_W(AW), .SCALE_SHIFT(0)) dut0 (
      .CLK(CLK), .RST(RST), .tData(tData), .tValid(tValid), .tLast(tLast), .tReady(tReady0),
      .value(value0), .valueValid(valueValid0), .valueLast(valueLast0), .valueReady(valueReady),
      .frameDone(frameDone0), .lastErr(lastErr0));

   ifft_data_output_handler #(.FRAME_LEN(FL), .ADDR_W(AW), .SCALE_SHIFT(2)) dut2 (
      .CLK(CLK), .RST(RST), .tData(tData), .tValid(tValid), .tLast(tLast), .tReady(tReady2),
      .value(value2), .valueValid(valueValid2), .valueLast(valueLast2), .valueReady(valueReady),
      .frameDone(frameDone2), .lastErr(lastErr2));

   // Reference scaling: floor(real / 2^sh) on the signed 16-bit real part
   function automatic logic [15:0] scaleRef(input logic [15:0] re, input int sh);
      int v;
      int d;
      int q;
      v = int'(signed'(re));
      d = 1 << sh;
      if (v >= 0) q = v / d;
      else        q = -((-v + d - 1) / d);
      return q[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic doReset();
      RST        = 1'b1;
      tValid     = 1'b0;
      tLast      = 1'b0;
      valueReady = 1'b0;
      step();
      chk("reset_outs0", {tReady0, valueValid0, valueLast0, frameDone0, lastErr0, value0}, 32'h0);
      chk("reset_outs2", {tReady2, valueValid2, valueLast2, frameDone2, lastErr2, value2}, 32'h0);
      RST = 1'b0;
      step();
      chk("reset_tready", {tReady0, tReady2}, 2'b11);
      modelErr = 1'b0;
   endtask

   // lastAt < 0 means no tLast; maxBeats truncates the frame (for reset tests)
   task automatic feedFrame(input int lastAt, input int gapMax, input int maxBeats);
      int len;
      len = (lastAt >= 0) ? lastAt + 1 : FL;
      expRaw.delete();
      for (int i = 0; i < len && i < maxBeats; i++) begin
         repeat ($urandom_range(0, gapMax)) begin
            tValid = 1'b0;
            tLast  = 1'b0;
            step();
            chk("tready_gap", {tReady0, tReady2}, 2'b11);
         end
         chk("tready_recv", {tReady0, tReady2}, 2'b11);
         if (dataPlan.size() > 0) tData = dataPlan.pop_front();
         else                     tData = $urandom;
         tValid = 1'b1;
         tLast  = (i == lastAt);
         expRaw.push_back(tData[15:0]);
         step();
      end
      tValid = 1'b0;
      tLast  = 1'b0;
      if (maxBeats >= len && lastAt != FL - 1) modelErr = 1'b1;
   endtask

   // readyMode: 0 always ready, 1 pattern 1,0,0,1, 2 random; stopAfter >= 0 aborts mid-frame
   task automatic drainFrame(input int readyMode, input int stopAfter);
      int  len;
      int  k;
      int  cyc;
      int  waitCnt;
      bit  started;
      bit  rdy;
      logic [3:0] pat;
      pat     = 4'b1001;
      len     = expRaw.size();
      k       = 0;
      cyc     = 0;
      waitCnt = 0;
      started = 0;
      while (k < len && cyc < 100 && !(stopAfter >= 0 && k >= stopAfter)) begin
         chk("tready_send", {tReady0, tReady2}, 2'b00);
         chk("framedone_early", {frameDone0, frameDone2}, 2'b00);
         if (started) chk("valid_cont", {valueValid0, valueValid2}, 2'b11);
         else if (!valueValid0) begin
            waitCnt++;
            if (waitCnt > 2) chk("valid_latency", {31'b0, valueValid0}, 32'h1);
         end
         if (valueValid0) begin
            started = 1;
            chk("value_s0", {16'b0, value0}, {16'b0, scaleRef(expRaw[k], 0)});
            chk("value_s2", {16'b0, value2}, {16'b0, scaleRef(expRaw[k], 2)});
            chk("value_last", {valueLast0, valueLast2}, (k == len - 1) ? 2'b11 : 2'b00);
            chk("valid_pair", {31'b0, valueValid2}, 32'h1);
         end
         case (readyMode)
            0:       rdy = 1'b1;
            1:       rdy = pat[cyc % 4];
            default: rdy = 1'($urandom % 2);
         endcase
         valueReady = rdy;
         if (valueValid0 && rdy) k++;
         cyc++;
         step();
      end
      if (stopAfter >= 0 && k >= stopAfter) return;
      chk("drain_count", k, len);
      chk("end_valid", {valueValid0, valueValid2}, 2'b00);
      chk("end_framedone", {frameDone0, frameDone2}, 2'b11);
      chk("end_tready", {tReady0, tReady2}, 2'b11);
      chk("end_lasterr", {lastErr0, lastErr2}, {modelErr, modelErr});
      valueReady = 1'b0;
      step();
      chk("framedone_pulse", {frameDone0, frameDone2}, 2'b00);
   endtask

   initial begin
      RST        = 1'b1;
      tData      = '0;
      tValid     = 1'b0;
      tLast      = 1'b0;
      valueReady = 1'b0;
      modelErr   = 1'b0;
      step();
      doReset();

      // normal frame: real parts 0..7, imaginary random
      for (int i = 0; i < FL; i++) dataPlan.push_back({16'($urandom), 16'(i)});
      feedFrame(FL - 1, 0, FL);
      drainFrame(0, -1);

      // scaling and sign corner values
      dataPlan.push_back({16'hABCD, 16'h8000});
      dataPlan.push_back({16'h1234, 16'hFFFF});
      dataPlan.push_back({16'hFFFF, 16'h7FFF});
      dataPlan.push_back({16'h0000, 16'h0004});
      feedFrame(FL - 1, 0, FL);
      drainFrame(0, -1);

      // back-pressure
      feedFrame(FL - 1, 0, FL);
      drainFrame(1, -1);

      // early tLast, then missing tLast
      feedFrame(4, 0, FL);
      drainFrame(0, -1);
      feedFrame(-1, 0, FL);
      drainFrame(2, -1);

      // reset mid-RECV then a clean frame
      feedFrame(-1, 0, 3);
      doReset();
      feedFrame(FL - 1, 0, FL);
      drainFrame(0, -1);

      // reset mid-SEND: no frameDone afterwards
      feedFrame(FL - 1, 0, FL);
      drainFrame(0, 3);
      doReset();
      repeat (3) begin
         chk("post_rst_idle", {frameDone0, frameDone2, valueValid0, valueValid2}, 4'b0000);
         chk("post_rst_tready", {tReady0, tReady2}, 2'b11);
         step();
      end
      feedFrame(FL - 1, 0, FL);
      drainFrame(0, -1);

      // tValid gaps
      feedFrame(FL - 1, 3, FL);
      drainFrame(2, -1);

      // random frames, including single-sample and missing-tLast frames
      for (int r = 0; r < 8; r++) begin
         int la;
         la = int'($urandom_range(0, FL)) - 1;
         feedFrame(la, 2, FL);
         drainFrame(2, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/ifft_data_output_handler.md
Name: ifft_data_output_handler

Overview:
- Receive side of the IFFT AXI-Stream link: slave that accepts complex IFFT output frames.
- Extracts and scales the real part of each beat and buffers one full frame.
- Replays the buffered frame to the downstream audio path over a valid/ready interface.
- Mirror of the IFFT input handler: CLK domain, same tData/tValid/tReady/tLast naming.

Parameters:
- FRAME_LEN, 1024: samples per IFFT frame (power of 2, ≥ 4).
- ADDR_W, 10: log2(FRAME_LEN); buffer address and counter width.
- SCALE_SHIFT, 0: arithmetic right shift applied to the real part (0..15).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- tData  in  32  IFFT output beat; [15:0] real (signed), [31:16] imaginary (ignored).
- tValid  in  1  IFFT beat valid.
- tLast  in  1  IFFT marks last beat of frame.
- tReady  out  1  handler can accept a beat.
- value  out  16  signed real sample to downstream.
- valueValid  out  1  value holds a valid sample.
- valueLast  out  1  current value is last sample of the frame.
- valueReady  in  1  downstream accepts value this cycle.
- frameDone  out  1  one-cycle pulse after the last sample of a frame is accepted downstream.
- lastErr  out  1  sticky tLast framing error flag.

Behaviour:
- Reset (RST high at a clock edge):
  - State becomes RECV; write pointer, frame length and read pointer clear to 0.
  - All outputs are registered and reset to 0: tReady, value, valueValid, valueLast, frameDone, lastErr.
  - tReady rises on the first edge with RST low.
  - Reset mid-frame (either state) discards the partial frame; no frameDone is produced.
- RECV state:
  - tReady = 1.
  - Beat accepted when tValid && tReady.
  - Stored word is tData[15:0] >>> SCALE_SHIFT (sign-extended arithmetic shift; truncation, no rounding), written to buf[wptr]; then wptr++.
- Frame end:
  - The accepted beat with tLast = 1, or the accepted beat at wptr = FRAME_LEN-1, whichever comes first, ends the frame.
  - Frame length = wptr + 1 at that beat.
  - tReady drops on the next edge; state moves to SEND.
- Framing errors (set lastErr, sticky until RST):
  - Early tLast (wptr < FRAME_LEN-1) is an error. The shortened frame is still sent with its true length.
  - Missing tLast on beat FRAME_LEN-1 is an error. The frame is sent as FRAME_LEN samples.
- SEND state:
  - tReady = 0; tValid is ignored.
  - Samples are presented in write order, index 0 .. len-1.
  - valueValid asserts no later than 2 cycles after the frame-ending beat is accepted.
  - Transfer occurs when valueValid && valueReady.
  - While valueValid = 1 and valueReady = 0, value and valueLast hold stable.
  - With valueReady held high, valueValid stays high for exactly len consecutive cycles (one sample per cycle, no bubbles). Synchronous buffer read needs prefetch or a skid register.
  - valueLast = 1 only together with index len-1.
- End of SEND:
  - On transfer of the last sample: valueValid = 0 next cycle, frameDone = 1 for exactly that one cycle.
  - State returns to RECV with tReady = 1 the same cycle; wptr = 0.
- No overlap: RECV and SEND never run concurrently (single buffer). The IFFT is back-pressured while draining.
- Pointer widths:
  - Pointers are ADDR_W bits; wptr never wraps because a frame ends at FRAME_LEN-1.
  - Frame length counter is ADDR_W+1 bits so that FRAME_LEN is representable.
- Simultaneous events:
  - RST overrides everything.
  - tLast arriving on beat FRAME_LEN-1 is a normal, error-free frame end.

Test Plan:
- Normal frame: FRAME_LEN = 8, SCALE_SHIFT = 0. Feed real parts 0..7, tLast on beat 7, valueReady = 1. Expect: value 0..7 on 8 consecutive cycles, valueLast on 7, frameDone one cycle later, lastErr = 0, tReady back high.
- Scaling and sign: SCALE_SHIFT = 2. Feed real parts 0x8000, 0xFFFF, 0x7FFF, 0x0004. Expect: 0xE000, 0xFFFF, 0x1FFF, 0x0001; imaginary bits have no effect.
- Back-pressure: toggle valueReady 1,0,0,1,... during SEND. Expect: value/valueValid held while valueReady = 0, no sample lost or duplicated; tReady stays 0 until frameDone.
- Framing errors:
  - tLast on beat 4 of an 8-sample frame: exactly 5 samples sent, valueLast on index 4, lastErr = 1.
  - Next frame with no tLast: 8 samples sent, lastErr stays 1.
- Reset mid-operation:
  - Assert RST after 3 beats in RECV: all outputs 0 next cycle, tReady 1 after RST drops; a fresh 8-beat frame then replays correctly.
  - Repeat with RST mid-SEND: no frameDone is produced.
- tValid gaps: insert idle cycles between input beats. Expect: identical output sequence, tReady stays 1 throughout RECV.
